mux4to1_registered: RTL and testbench

- Registered 4-to-1 word multiplexer: selects one of four WIDTH-bit data inputs by a 2-bit select and presents it on a registered output one clock later.
- Sits in the display/datapath steering logic, choosing which 16-bit source (e.g. raw count, scaled value, BCD, constant) feeds downstream blocks.
- Adds an enable, an output-valid flag and a select-change pulse so downstream logic can tell when the output source has switched.

---
 rtl/mux4to1_registered.sv | 56 +++++
 tb/tb_mux4to1_registered.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux4to1_registered.sv
// ============================================================================
// mux4to1_registered : registered 4-to-1 word mux with valid and select-change flags
// Revision 1.0
// ============================================================================
`default_nettype none

module mux4to1_registered #(
   parameter int               WIDTH       = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic [1:0]       s,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [WIDTH-1:0] in3,
   input  logic [WIDTH-1:0] in4,
   output logic [WIDTH-1:0] mux_out,
   output logic             out_valid,
   output logic [1:0]       sel_q,
   output logic             sel_changed
);

   logic [WIDTH-1:0] sel_data;

   always_comb begin
      sel_data = in1;
      case (s)
         2'b00: sel_data = in1;
         2'b01: sel_data = in2;
         2'b10: sel_data = in3;
         2'b11: sel_data = in4;
      endcase
   end

   // The first enabled capture after reset always counts as a source switch.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mux_out     <= RESET_VALUE;
         out_valid   <= 1'b0;
         sel_q       <= 2'b00;
         sel_changed <= 1'b0;
      end else if (en) begin
         mux_out     <= sel_data;
         sel_q       <= s;
         out_valid   <= 1'b1;
         sel_changed <= (s != sel_q) || !out_valid;
      end else begin
         sel_changed <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mux4to1_registered.sv
// ============================================================================
// tb_mux4to1_registered : scoreboard bench for mux4to1_registered
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mux4to1_registered;

   typedef struct packed {
      logic [15:0] mux;
      logic        valid;
      logic [1:0]  sel;
      logic        chg;
   } outs_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        en = 1'b0;
   logic [1:0]  s = 2'b00;
   logic [15:0] in1 = 16'hFFFF, in2 = 16'hFFFF, in3 = 16'hFFFF, in4 = 16'hFFFF;
   logic [15:0] mux_out;
   logic        out_valid;
   logic [1:0]  sel_q;
   logic        sel_changed;

   int    n_checks = 0;
   int    n_fail   = 0;
   outs_t model    = '0;
   outs_t sb[$];
   outs_t exp_o, obs;

   mux4to1_registered #(.WIDTH(16), .RESET_VALUE(16'h0000)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .en         (en),
      .s          (s),
      .in1        (in1),
      .in2        (in2),
      .in3        (in3),
      .in4        (in4),
      .mux_out    (mux_out),
      .out_valid  (out_valid),
      .sel_q      (sel_q),
      .sel_changed(sel_changed)
   );

   always #5 clk = ~clk;

   function automatic outs_t predict(outs_t cur);
      outs_t n;
      logic [15:0] d;
      if (!reset_n) return '0;
      if (!en) begin
         n = cur;
         n.chg = 1'b0;
         return n;
      end
      d = (s == 2'd0) ? in1 : (s == 2'd1) ? in2 : (s == 2'd2) ? in3 : in4;
      n.mux   = d;
      n.valid = 1'b1;
      n.sel   = s;
      n.chg   = (s != cur.sel) || !cur.valid;
      return n;
   endfunction

   // Push the prediction for the coming edge, then advance past it.
   task automatic tick();
      outs_t p;
      p = predict(model);
      sb.push_back(p);
      @(posedge clk);
      #1;
      model = p;
   endtask

   function automatic outs_t observe();
      return {mux_out, out_valid, sel_q, sel_changed};
   endfunction

   task automatic test_reset();
      reset_n = 1'b0; en = 1'b1; s = 2'b11;
      in1 = 16'hFFFF; in2 = 16'hFFFF; in3 = 16'hFFFF; in4 = 16'hFFFF;
      repeat (2) @(posedge clk);
      #1;
      obs = observe();
      n_checks++;
      if (obs !== 20'h0) begin
         n_fail++;
         $display("FAIL reset_state: got %h required %h", obs, 20'h0);
      end
      model = '0;
      reset_n = 1'b1;
   endtask

   task automatic test_select(input logic [1:0] sel);
      in1 = 16'hFFFF; in2 = 16'hFFFF; in3 = 16'hFFFF; in4 = 16'hFFFF;
      s = sel;
      case (sel)
         2'd0: in1 = 16'hA5A5;
         2'd1: in2 = 16'hA5A5;
         2'd2: in3 = 16'hA5A5;
         default: in4 = 16'hA5A5;
      endcase
      for (int k = 0; k < 3; k++) begin
         if (k == 2) begin
            case (sel)
               2'd0: in1 = 16'h5A5A;
               2'd1: in2 = 16'h5A5A;
               2'd2: in3 = 16'h5A5A;
               default: in4 = 16'h5A5A;
            endcase
         end
         tick();
         exp_o = sb.pop_front();
         obs = observe();
         n_checks++;
         if (obs !== exp_o || mux_out === 16'hFFFF) begin
            n_fail++;
            $display("FAIL select_%0d step%0d: got %h required %h", sel, k, obs, exp_o);
         end
      end
   endtask

   task automatic test_select_change();
      logic [1:0] seq [5] = '{2'd0, 2'd0, 2'd3, 2'd3, 2'd3};
      for (int k = 0; k < 5; k++) begin
         s = seq[k];
         in1 = 16'h1111 + 16'(k); in4 = 16'h4444 + 16'(k);
         tick();
         exp_o = sb.pop_front();
         obs = observe();
         n_checks++;
         if (obs !== exp_o) begin
            n_fail++;
            $display("FAIL select_change step%0d: got %h required %h", k, obs, exp_o);
         end
      end
   endtask

   task automatic test_enable_hold();
      en = 1'b1; s = 2'd0; in1 = 16'h5A5A;
      for (int k = 0; k < 4; k++) begin
         if (k == 1) begin
            en = 1'b0; s = 2'd2;
            in1 = 16'h1234; in2 = 16'h2345; in3 = 16'h3456; in4 = 16'h4567;
         end
         if (k == 2) begin
            in3 = 16'h0F0F; s = 2'd1;
         end
         if (k == 3) begin
            en = 1'b1; s = 2'd2;
         end
         tick();
         exp_o = sb.pop_front();
         obs = observe();
         n_checks++;
         if (obs !== exp_o) begin
            n_fail++;
            $display("FAIL enable_hold step%0d: got %h required %h", k, obs, exp_o);
         end
      end
   endtask

   task automatic test_isolation();
      s = 2'd2; in3 = 16'hC3C3;
      for (int k = 0; k < 6; k++) begin
         in1 = 16'($urandom); in2 = 16'($urandom); in4 = 16'($urandom);
         tick();
         exp_o = sb.pop_front();
         obs = observe();
         n_checks++;
         if (obs !== exp_o || mux_out !== 16'hC3C3) begin
            n_fail++;
            $display("FAIL isolation step%0d: got %h required %h", k, obs, exp_o);
         end
      end
   endtask

   task automatic test_reset_mid();
      s = 2'd1; in2 = 16'hBEEF;
      tick();
      void'(sb.pop_front());
      reset_n = 1'b0;
      #1;
      obs = observe();
      n_checks++;
      if (obs !== 20'h0) begin
         n_fail++;
         $display("FAIL reset_async: got %h required %h", obs, 20'h0);
      end
      model = '0;
      #2;
      reset_n = 1'b1;
      s = 2'd0; in1 = 16'h7E7E;
      tick();
      exp_o = sb.pop_front();
      obs = observe();
      n_checks++;
      if (obs !== exp_o || sel_changed !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release: got %h required %h", obs, exp_o);
      end
      tick();
      exp_o = sb.pop_front();
      obs = observe();
      n_checks++;
      if (obs !== exp_o) begin
         n_fail++;
         $display("FAIL reset_release_hold: got %h required %h", obs, exp_o);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      en = 1'b1;
      for (int k = 0; k < 4; k++) test_select(2'(k));
      test_select_change();
      test_enable_hold();
      test_isolation();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
